// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x30 character-cell pixel source with host write port and clear engine.
// Define CURSOR_BLINK_EN to build the blinking cursor (frame counter plus FG/BG swap on one cell).
module vga_text_renderer #(
    parameter logic [11:0] FG_COLOUR    = 12'hFFF,
    parameter logic [11:0] BG_COLOUR    = 12'h000,
    parameter logic [7:0]  BLANK_CHAR   = 8'h20,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PIX_EN,
    input  logic [9:0]  ADDRH,
    input  logic [8:0]  ADDRV,
    input  logic        REFRESH,
    output logic [11:0] COLOUR,
    output logic [11:0] FONT_ADDR,
    input  logic [7:0]  FONT_DATA,
    input  logic        WR_REQ,
    input  logic [11:0] WR_ADDR,
    input  logic [7:0]  WR_DATA,
    output logic        WR_ACK,
    input  logic        CLEAR,
    output logic        BUSY,
    input  logic [11:0] CURSOR_ADDR
);

    localparam logic [11:0] NUM_CELLS = 12'd2400;
    localparam logic [11:0] LAST_CELL = 12'd2399;

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WACK = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] clr_ptr_q, clr_ptr_d;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [7:0]  ram_wdata;

    logic [7:0]  mem [0:2399];

    logic [6:0]  col;
    logic [4:0]  row;
    logic [11:0] index;
    logic        in_range;

    logic [7:0]  chr_q;
    logic [2:0]  xbit1_q, xbit2_q;
    logic [3:0]  grow1_q;
    logic        inr1_q, inr2_q;
    logic [11:0] font_addr_q;
    logic [11:0] colour_q, colour_d;
    logic        swap;
    logic        pix;

    assign col      = ADDRH[9:3];
    assign row      = ADDRV[8:4];
    assign index    = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
    assign in_range = (ADDRH < 10'd640) && (ADDRV < 9'd480);

    // Reads only on PIX_EN=1 and writes only on PIX_EN=0, so one port serves both.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (PIX_EN) begin
            chr_q <= (index < NUM_CELLS) ? mem[index] : BLANK_CHAR;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            xbit1_q     <= '0;
            grow1_q     <= '0;
            inr1_q      <= 1'b0;
            xbit2_q     <= '0;
            inr2_q      <= 1'b0;
            font_addr_q <= '0;
            colour_q    <= '0;
        end else if (PIX_EN) begin
            xbit1_q     <= ADDRH[2:0];
            grow1_q     <= ADDRV[3:0];
            inr1_q      <= in_range;
            font_addr_q <= {chr_q, grow1_q};
            xbit2_q     <= xbit1_q;
            inr2_q      <= inr1_q;
            colour_q    <= colour_d;
        end
    end

    always_comb begin
        pix      = FONT_DATA[3'd7 - xbit2_q] ^ swap;
        colour_d = '0;
        if (inr2_q) begin
            colour_d = pix ? FG_COLOUR : BG_COLOUR;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [31:0] frame_q;
    logic        blink_q;
    logic        cur1_q, cur2_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_q <= '0;
            blink_q <= 1'b0;
            cur1_q  <= 1'b0;
            cur2_q  <= 1'b0;
        end else begin
            if (REFRESH) begin
                if (frame_q == 32'(BLINK_FRAMES - 1)) begin
                    frame_q <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    frame_q <= frame_q + 32'd1;
                end
            end
            if (PIX_EN) begin
                cur1_q <= (index == CURSOR_ADDR);
                cur2_q <= cur1_q;
            end
        end
    end

    assign swap = cur2_q & blink_q;
`else
    logic unused_cursor;
    assign unused_cursor = ^{CURSOR_ADDR, REFRESH, BLINK_FRAMES};
    assign swap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ram_we    = 1'b0;
        ram_waddr = clr_ptr_q;
        ram_wdata = BLANK_CHAR;
        case (state_q)
            ST_CLR: begin
                if (CLEAR) begin
                    clr_ptr_d = '0;
                end else if (!PIX_EN) begin
                    ram_we = 1'b1;
                    if (clr_ptr_q == LAST_CELL) begin
                        state_d = ST_IDLE;
                    end else begin
                        clr_ptr_d = clr_ptr_q + 12'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (CLEAR) begin
                    clr_ptr_d = '0;
                    state_d   = ST_CLR;
                end else if (WR_REQ && !PIX_EN) begin
                    ram_we    = (WR_ADDR < NUM_CELLS);
                    ram_waddr = WR_ADDR;
                    ram_wdata = WR_DATA;
                    state_d   = ST_WACK;
                end
            end
            ST_WACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_CLR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_CLR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign WR_ACK    = (state_q == ST_WACK);
    assign BUSY      = (state_q == ST_CLR);
    assign COLOUR    = colour_q;
    assign FONT_ADDR = font_addr_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Testbench for vga_text_renderer: randomized pixel scans and host writes checked against
// a character-grid reference model (cell array, font array, cursor blink from pulse count).
module tb_vga_text_renderer;

    localparam int BF = 2;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        PIX_EN;
    logic [9:0]  ADDRH;
    logic [8:0]  ADDRV;
    logic        REFRESH;
    logic [11:0] COLOUR;
    logic [11:0] FONT_ADDR;
    logic [7:0]  FONT_DATA;
    logic        WR_REQ;
    logic [11:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic        WR_ACK;
    logic        CLEAR;
    logic        BUSY;
    logic [11:0] CURSOR_ADDR;

    vga_text_renderer #(
        .FG_COLOUR   (12'hFFF),
        .BG_COLOUR   (12'h000),
        .BLANK_CHAR  (8'h20),
        .BLINK_FRAMES(BF)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PIX_EN     (PIX_EN),
        .ADDRH      (ADDRH),
        .ADDRV      (ADDRV),
        .REFRESH    (REFRESH),
        .COLOUR     (COLOUR),
        .FONT_ADDR  (FONT_ADDR),
        .FONT_DATA  (FONT_DATA),
        .WR_REQ     (WR_REQ),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .WR_ACK     (WR_ACK),
        .CLEAR      (CLEAR),
        .BUSY       (BUSY),
        .CURSOR_ADDR(CURSOR_ADDR)
    );

    always #5 CLK = ~CLK;

    logic [7:0] font_rom [0:4095];
    logic [7:0] cells    [0:2399];
    assign FONT_DATA = font_rom[FONT_ADDR];

    int n_checks = 0;
    int n_fail   = 0;
    int pat      = 0;
    int refresh_pulses = 0;
    int sh[$];
    int sv[$];

    // ---------------- reference model ----------------
    function automatic logic model_blink();
`ifdef CURSOR_BLINK_EN
        return ((refresh_pulses / BF) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] ref_colour(input int h, input int v);
        int idx;
        int fi;
        logic [7:0] glyph;
        logic b;
        if (h >= 640 || v >= 480) return 12'h000;
        idx   = (v / 16) * 80 + (h / 8);
        fi    = int'(cells[idx]) * 16 + (v % 16);
        glyph = font_rom[fi];
        b     = glyph[7 - (h % 8)];
        if (model_blink() && idx == int'(CURSOR_ADDR)) b = ~b;
        return b ? 12'hFFF : 12'h000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2400; i++) cells[i] = 8'h20;
    endtask

    task automatic fill_font_const(input logic [7:0] d);
        for (int i = 0; i < 4096; i++) font_rom[i] = d;
    endtask

    task automatic fill_font_rand();
        for (int i = 0; i < 4096; i++) font_rom[i] = 8'($urandom);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic run_cyc(output logic pe);
        pe = ((pat % 4) == 0);
        pat++;
        PIX_EN = pe;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_clear(output int zeros, output bit done);
        logic pe;
        zeros = 0;
        done  = 0;
        for (int n = 0; n < 20000; n++) begin
            if (BUSY !== 1'b1) begin
                done = 1;
                break;
            end
            run_cyc(pe);
            if (!pe) zeros++;
        end
    endtask

    task automatic pulse_clear();
        logic pe;
        CLEAR = 1'b1;
        run_cyc(pe);
        CLEAR = 1'b0;
    endtask

    task automatic push_pix(input int h, input int v);
        sh.push_back(h);
        sv.push_back(v);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 8)
                push_pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
            else
                push_pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
        end
    endtask

    task automatic push_cell(input int idx, input int n);
        for (int i = 0; i < n; i++)
            push_pix((idx % 80) * 8 + int'($urandom_range(0, 7)),
                     (idx / 80) * 16 + int'($urandom_range(0, 15)));
    endtask

    // Drives the queued addresses on consecutive ticks; COLOUR after tick k+2 belongs to tick k.
    task automatic scan_run(input string name);
        int qh[$];
        int qv[$];
        int h;
        int v;
        logic [11:0] exp;
        int total;
        total = sh.size();
        for (int i = 0; i < total + 2; i++) begin
            if (i < total) begin
                ADDRH = 10'(sh[i]);
                ADDRV = 9'(sv[i]);
            end
            PIX_EN = 1'b1;
            @(posedge CLK);
            #1;
            qh.push_back(int'(ADDRH));
            qv.push_back(int'(ADDRV));
            if (qh.size() == 3) begin
                h   = qh.pop_front();
                v   = qv.pop_front();
                exp = ref_colour(h, v);
                n_checks++;
                if (COLOUR !== exp) begin
                    n_fail++;
                    $display("FAIL %s pixel(%0d,%0d): COLOUR=%h expected %h", name, h, v, COLOUR, exp);
                end
            end
        end
        PIX_EN = 1'b0;
        sh.delete();
        sv.delete();
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input string name, output int zeros);
        logic pe;
        bit   seen;
        pe = 1'b1;
        seen = 0;
        zeros = 0;
        WR_REQ  = 1'b1;
        WR_ADDR = 12'(a);
        WR_DATA = d;
        for (int n = 0; n < 20000; n++) begin
            run_cyc(pe);
            if (!pe) zeros++;
            if (WR_ACK === 1'b1) begin
                seen = 1;
                break;
            end
        end
        WR_REQ = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s ack: WR_ACK never seen, expected a pulse", name);
        end else begin
            n_checks++;
            if (pe !== 1'b0) begin
                n_fail++;
                $display("FAIL %s commit: PIX_EN=%b at commit, expected 0", name, pe);
            end
            run_cyc(pe);
            n_checks++;
            if (WR_ACK !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ack_width: WR_ACK=%b, expected 0", name, WR_ACK);
            end
            run_cyc(pe);
            run_cyc(pe);
            n_checks++;
            if (WR_ACK !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ack_retrigger: WR_ACK=%b, expected 0", name, WR_ACK);
            end
        end
        if (a < 2400) cells[a] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int zeros;
        bit done;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (COLOUR !== 12'h000) begin n_fail++; $display("FAIL reset_colour: COLOUR=%h expected 000", COLOUR); end
        n_checks++;
        if (FONT_ADDR !== 12'h000) begin n_fail++; $display("FAIL reset_font_addr: FONT_ADDR=%h expected 000", FONT_ADDR); end
        n_checks++;
        if (WR_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: WR_ACK=%b expected 0", WR_ACK); end
        n_checks++;
        if (BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_busy: BUSY=%b expected 1", BUSY); end
        RESET_N = 1'b1;
        refresh_pulses = 0;
        model_clear();
        wait_clear(zeros, done);
        n_checks++;
        if (!done || zeros != 2400) begin
            n_fail++;
            $display("FAIL reset_clear_len: %0d PIX_EN=0 cycles (done=%0d), expected 2400", zeros, done);
        end
    endtask

    task automatic test_blank_frame();
        fill_font_const(8'h00);
        push_rand(300);
        scan_run("blank_font");
        fill_font_rand();
        push_rand(300);
        scan_run("blank_cells");
    endtask

    task automatic test_write_81();
        int zeros;
        fill_font_const(8'h80);
        do_write(81, 8'h41, "wr81", zeros);
        push_pix(8, 16);
        push_pix(9, 16);
        push_pix(15, 16);
        push_pix(16, 16);
        push_pix(8, 31);
        push_pix(647, 16);
        scan_run("wr81_pix");
        fill_font_rand();
        push_cell(81, 40);
        scan_run("wr81_glyph");
    endtask

    task automatic test_random_writes();
        int zeros;
        int addrs[$];
        int a;
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 2399));
            addrs.push_back(a);
            do_write(a, 8'($urandom), "rand_wr", zeros);
        end
        fill_font_rand();
        foreach (addrs[i]) push_cell(addrs[i], 6);
        push_rand(150);
        scan_run("rand_wr_scan");
    endtask

    task automatic test_oob_write();
        int zeros;
        do_write(2400, 8'hEE, "oob2400", zeros);
        do_write(4095, 8'hEF, "oob4095", zeros);
        push_cell(0, 10);
        push_cell(2399, 10);
        push_rand(150);
        scan_run("oob_scan");
    endtask

    task automatic test_out_of_range();
        fill_font_const(8'hFF);
        for (int i = 0; i < 60; i++) push_pix(int'($urandom_range(640, 1023)), int'($urandom_range(0, 511)));
        push_pix(700, 0);
        push_pix(700, 100);
        for (int i = 0; i < 40; i++) push_pix(int'($urandom_range(0, 1023)), int'($urandom_range(480, 511)));
        push_pix(639, 479);
        scan_run("out_of_range");
    endtask

    task automatic test_write_during_clear();
        int zeros;
        fill_font_rand();
        pulse_clear();
        model_clear();
        do_write(1234, 8'h5A, "stall_wr", zeros);
        n_checks++;
        if (zeros != 2401) begin
            n_fail++;
            $display("FAIL stall_commit_time: %0d PIX_EN=0 cycles before ack, expected 2401", zeros);
        end
        n_checks++;
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL stall_busy: BUSY=%b expected 0", BUSY); end
        push_cell(1234, 30);
        push_rand(100);
        scan_run("stall_scan");
    endtask

    task automatic test_clear_restart();
        int zeros;
        bit done;
        logic pe;
        pulse_clear();
        for (int i = 0; i < 400; i++) run_cyc(pe);
        pulse_clear();
        model_clear();
        wait_clear(zeros, done);
        n_checks++;
        if (!done || zeros != 2400) begin
            n_fail++;
            $display("FAIL restart_clear_len: %0d PIX_EN=0 cycles (done=%0d), expected 2400", zeros, done);
        end
        fill_font_rand();
        push_rand(200);
        scan_run("restart_scan");
    endtask

    task automatic test_reset_midclear();
        int zeros;
        bit done;
        logic pe;
        for (int i = 0; i < 5; i++) do_write(int'($urandom_range(0, 2399)), 8'($urandom), "pre_rst_wr", zeros);
        pulse_clear();
        for (int i = 0; i < 300; i++) run_cyc(pe);
        RESET_N = 1'b0;
        run_cyc(pe);
        n_checks++;
        if (BUSY !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: BUSY=%b expected 1", BUSY); end
        RESET_N = 1'b1;
        refresh_pulses = 0;
        model_clear();
        wait_clear(zeros, done);
        n_checks++;
        if (!done || zeros != 2400) begin
            n_fail++;
            $display("FAIL midrst_clear_len: %0d PIX_EN=0 cycles (done=%0d), expected 2400", zeros, done);
        end
        push_rand(150);
        scan_run("midrst_scan");
    endtask

`ifdef CURSOR_BLINK_EN
    task automatic test_cursor();
        logic pe;
        fill_font_const(8'hFF);
        CURSOR_ADDR = 12'd0;
        for (int p = 0; p <= 4; p++) begin
            push_cell(0, 12);
            push_cell(1, 6);
            scan_run("cursor_scan");
            REFRESH = 1'b1;
            run_cyc(pe);
            REFRESH = 1'b0;
            refresh_pulses++;
            run_cyc(pe);
        end
    endtask
`endif

    initial begin
        RESET_N = 1'b0;
        PIX_EN = 1'b0;
        ADDRH = '0;
        ADDRV = '0;
        REFRESH = 1'b0;
        WR_REQ = 1'b0;
        WR_ADDR = '0;
        WR_DATA = '0;
        CLEAR = 1'b0;
        CURSOR_ADDR = '0;
        fill_font_const(8'h00);
        model_clear();

        test_reset();
        test_blank_frame();
        test_write_81();
        test_random_writes();
        test_oob_write();
        test_out_of_range();
        test_write_during_clear();
        test_clear_restart();
        test_reset_midclear();
`ifdef CURSOR_BLINK_EN
        test_cursor();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
